lcd_cmd_arbiter: RTL and testbench

- Command scheduler in front of the 12x9 LCD image controller.
- Two host requesters queue 3-bit LCD commands into private FIFOs; the block arbitrates between them round-robin and issues one command at a time under the controller's busy handshake.
- For LOAD it streams 108 pixels from a pixel-source memory.
- It tracks the 16 output pixels of each command and reports completion per requester.

---
 rtl/lcd_pkg.sv | 40 ++++
 rtl/lcd_cmd_fifo.sv | 54 +++++
 rtl/lcd_cmd_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_lcd_cmd_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler.
//   - 3-bit LCD command encoding, including the reserved code 7
//   - image geometry (12x9) and the per-command output pixel count
//   - scheduler FSM state encoding
package lcd_pkg;

   localparam int CMD_W      = 3;
   localparam int IMG_W      = 12;
   localparam int IMG_H      = 9;
   localparam int IMG_PIXELS = IMG_W * IMG_H;
   localparam int OUT_PIXELS = 16;

   typedef enum logic [CMD_W-1:0] {
      CMD_LOAD     = 3'd0,
      CMD_ZOOM_IN  = 3'd1,
      CMD_ZOOM_FIT = 3'd2,
      CMD_SHIFT_R  = 3'd3,
      CMD_SHIFT_L  = 3'd4,
      CMD_SHIFT_U  = 3'd5,
      CMD_SHIFT_D  = 3'd6,
      CMD_RSVD     = 3'd7
   } lcd_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_ISSUE,
      ST_LOAD,
      ST_WAIT_OUT,
      ST_WAIT_IDLE
   } lcd_state_t;

   // A popped command is discarded when it is the reserved code, or when it
   // needs an image and none has been loaded yet.
   function automatic logic cmd_is_drop(input logic [CMD_W-1:0] cmd,
                                        input logic             img_loaded);
      return (cmd == CMD_RSVD) || ((cmd != CMD_LOAD) && !img_loaded);
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Per-requester command FIFO: synchronous, show-ahead head (rdata is the
// oldest entry whenever !empty).
// Ports:
//   clk, reset        clock / synchronous active-high reset
//   push, wdata       write strobe and data (ignored while full)
//   pop               remove head (ignored while empty)
//   rdata             head entry
//   full, empty       occupancy flags
module lcd_cmd_fifo
   import lcd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit tells full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Command scheduler in front of the 12x9 LCD image controller.
// Two requesters queue 3-bit commands into private FIFOs; commands are
// granted round-robin and issued one at a time under the LCD busy handshake.
// LOAD streams IMG_PIXELS pixels from the pixel-source memory; every issued
// command is retired after OUT_PIXELS output strobes and busy low.
// Ports:
//   clk, reset                      clock / synchronous active-high reset
//   reqN_cmd/valid/ready            requester N push interface (N = 0, 1)
//   pix_addr, pix_data              pixel-source read (combinational data)
//   lcd_cmd, lcd_cmd_valid          command issue to the LCD (1-cycle strobe)
//   lcd_datain                      registered pixel stream during LOAD
//   lcd_busy, lcd_output_valid      LCD status inputs
//   done, done_id                   completion pulse and owning requester
//   err                             pulse on dropped command or watchdog
// Build option: define LCD_CMD_WDOG_EN to add a watchdog that abandons a
// command stuck for WDOG_CYCLES in ISSUE / WAIT_OUT / WAIT_IDLE.
module lcd_cmd_arbiter #(
   parameter int FIFO_DEPTH  = 4,
   parameter int IMG_PIXELS  = lcd_pkg::IMG_PIXELS,
   parameter int OUT_PIXELS  = lcd_pkg::OUT_PIXELS,
   parameter int WDOG_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req0_cmd,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [2:0] req1_cmd,
   input  logic       req1_valid,
   output logic       req1_ready,
   output logic [6:0] pix_addr,
   input  logic [7:0] pix_data,
   output logic [2:0] lcd_cmd,
   output logic       lcd_cmd_valid,
   output logic [7:0] lcd_datain,
   input  logic       lcd_busy,
   input  logic       lcd_output_valid,
   output logic       done,
   output logic       done_id,
   output logic       err
);

   localparam int NUM_REQ = 2;
   localparam int CW      = lcd_pkg::CMD_W;

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
       (IMG_PIXELS < 1) || (IMG_PIXELS > 128) || (OUT_PIXELS < 1) ||
       (OUT_PIXELS > 127) || (WDOG_CYCLES < 1)) begin : g_bad_params
      $error("lcd_cmd_arbiter: unsupported parameter set");
   end

   lcd_pkg::lcd_state_t state_q, state_d;

   logic [NUM_REQ-1:0][CW-1:0] in_cmd;
   logic [NUM_REQ-1:0][CW-1:0] head_cmd;
   logic [NUM_REQ-1:0]         in_valid;
   logic [NUM_REQ-1:0]         fifo_full;
   logic [NUM_REQ-1:0]         fifo_empty;
   logic [NUM_REQ-1:0]         fifo_push;
   logic [NUM_REQ-1:0]         fifo_pop;

   logic          rr_q;          // requester of the last completed command
   logic          img_loaded_q;
   logic [CW-1:0] cur_cmd;
   logic          cur_id;
   logic [6:0]    out_cnt;

   logic          grant_id;
   logic [CW-1:0] grant_cmd;
   logic          busy_eff;
   logic          pop_en, drop_en, issue_en, load_end, done_en, wdog_to;

   // ---------------------------------------------------------------- FIFOs
   assign in_cmd   = {req1_cmd, req0_cmd};
   assign in_valid = {req1_valid, req0_valid};

   // Ready follows not-full only; held low while reset is asserted.
   assign req0_ready = ~fifo_full[0] & ~reset;
   assign req1_ready = ~fifo_full[1] & ~reset;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign fifo_push[g] = in_valid[g] & ~fifo_full[g];
      assign fifo_pop[g]  = pop_en & (grant_id == 1'(g));

      lcd_cmd_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (CW)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (fifo_push[g]),
         .wdata (in_cmd[g]),
         .pop   (fifo_pop[g]),
         .rdata (head_cmd[g]),
         .full  (fifo_full[g]),
         .empty (fifo_empty[g])
      );
   end

   // ------------------------------------------------------------- arbiter
   // Both pending: take the requester that did not complete last.
   // One pending: take it.
   always_comb begin
      grant_id = 1'b0;
      if (!fifo_empty[0] && !fifo_empty[1])
         grant_id = ~rr_q;
      else if (fifo_empty[0])
         grant_id = 1'b1;
   end

   assign grant_cmd = head_cmd[grant_id];

   // The LCD raises busy a cycle late, so busy seen in the issue-strobe
   // cycle is stale and must not hold up the handshake.
   assign busy_eff = lcd_busy & ~lcd_cmd_valid;

   // ------------------------------------------------------------ watchdog
`ifdef LCD_CMD_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

   logic [WDOG_W-1:0] wdog_cnt;
   logic              wdog_state;

   assign wdog_state = (state_q == lcd_pkg::ST_ISSUE)    ||
                       (state_q == lcd_pkg::ST_WAIT_OUT) ||
                       (state_q == lcd_pkg::ST_WAIT_IDLE);

   always_ff @(posedge clk) begin
      if (reset)
         wdog_cnt <= '0;
      else if (!wdog_state || (state_d != state_q))
         wdog_cnt <= '0;
      else
         wdog_cnt <= wdog_cnt + 1'b1;
   end

   assign wdog_to = wdog_state && (wdog_cnt == WDOG_W'(WDOG_CYCLES));
`else
   assign wdog_to = 1'b0;
`endif

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= lcd_pkg::ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pop_en   = 1'b0;
      drop_en  = 1'b0;
      issue_en = 1'b0;
      load_end = 1'b0;
      done_en  = 1'b0;
      case (state_q)
         lcd_pkg::ST_IDLE: begin
            if (fifo_empty != '1)
               state_d = lcd_pkg::ST_ARB;
         end
         lcd_pkg::ST_ARB: begin
            pop_en = 1'b1;
            if (lcd_pkg::cmd_is_drop(grant_cmd, img_loaded_q)) begin
               drop_en = 1'b1;
               state_d = lcd_pkg::ST_IDLE;
            end else begin
               state_d = lcd_pkg::ST_ISSUE;
            end
         end
         lcd_pkg::ST_ISSUE: begin
            if (!busy_eff) begin
               issue_en = 1'b1;
               state_d  = (cur_cmd == lcd_pkg::CMD_LOAD) ? lcd_pkg::ST_LOAD
                                                         : lcd_pkg::ST_WAIT_OUT;
            end
         end
         lcd_pkg::ST_LOAD: begin
            if (pix_addr == 7'(IMG_PIXELS - 1)) begin
               load_end = 1'b1;
               state_d  = lcd_pkg::ST_WAIT_OUT;
            end
         end
         lcd_pkg::ST_WAIT_OUT: begin
            if (out_cnt >= 7'(OUT_PIXELS))
               state_d = lcd_pkg::ST_WAIT_IDLE;
         end
         lcd_pkg::ST_WAIT_IDLE: begin
            if (!busy_eff) begin
               done_en = 1'b1;
               state_d = lcd_pkg::ST_IDLE;
            end
         end
         default: state_d = lcd_pkg::ST_IDLE;
      endcase
      // A timed-out command is abandoned: no issue, no done.
      if (wdog_to) begin
         issue_en = 1'b0;
         done_en  = 1'b0;
         state_d  = lcd_pkg::ST_IDLE;
      end
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q          <= 1'b0;
         img_loaded_q  <= 1'b0;
         cur_cmd       <= '0;
         cur_id        <= 1'b0;
         out_cnt       <= '0;
         pix_addr      <= '0;
         lcd_cmd       <= '0;
         lcd_cmd_valid <= 1'b0;
         lcd_datain    <= '0;
         done          <= 1'b0;
         done_id       <= 1'b0;
         err           <= 1'b0;
      end else begin
         lcd_cmd_valid <= issue_en;
         done          <= done_en;
         err           <= drop_en | wdog_to;

         if (pop_en) begin
            cur_cmd <= grant_cmd;
            cur_id  <= grant_id;
         end

         if (issue_en) begin
            lcd_cmd  <= cur_cmd;
            pix_addr <= '0;
            out_cnt  <= '0;
         end

         // Address k is driven in cycle T+k; its data lands on lcd_datain
         // one cycle later.
         if (state_q == lcd_pkg::ST_LOAD) begin
            lcd_datain <= pix_data;
            pix_addr   <= load_end ? 7'd0 : pix_addr + 7'd1;
         end

         if (load_end)
            img_loaded_q <= 1'b1;

         // Output strobes during LOAD count toward the command's total;
         // strobes after the total is reached are ignored.
         if (lcd_output_valid &&
             ((state_q == lcd_pkg::ST_LOAD) || (state_q == lcd_pkg::ST_WAIT_OUT)))
            out_cnt <= out_cnt + 7'd1;

         if (done_en) begin
            done_id <= cur_id;
            rr_q    <= cur_id;
         end
      end
   end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
module tb_lcd_cmd_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req0_cmd, req1_cmd;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [6:0] pix_addr;
   logic [7:0] pix_data;
   logic [2:0] lcd_cmd;
   logic       lcd_cmd_valid;
   logic [7:0] lcd_datain;
   logic       lcd_busy;
   logic       lcd_output_valid;
   logic       done, done_id, err;

   logic       stub_busy, hold_busy, stub_mute;
   logic [7:0] pix_mem [128];

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0, err_cnt = 0, issue_cnt = 0;
   logic [2:0] issued_q[$];
   logic       done_ids[$];

   always #5 clk = ~clk;

   assign pix_data = pix_mem[pix_addr];
   assign lcd_busy = stub_busy | hold_busy;

   lcd_cmd_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .req0_cmd         (req0_cmd),
      .req0_valid       (req0_valid),
      .req0_ready       (req0_ready),
      .req1_cmd         (req1_cmd),
      .req1_valid       (req1_valid),
      .req1_ready       (req1_ready),
      .pix_addr         (pix_addr),
      .pix_data         (pix_data),
      .lcd_cmd          (lcd_cmd),
      .lcd_cmd_valid    (lcd_cmd_valid),
      .lcd_datain       (lcd_datain),
      .lcd_busy         (lcd_busy),
      .lcd_output_valid (lcd_output_valid),
      .done             (done),
      .done_id          (done_id),
      .err              (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int target);
      int b = 0;
      while (done_cnt < target && b < 2000) begin
         step();
         b++;
      end
      chk("done_count", done_cnt, target);
   endtask

   // LCD stub: busy after each issue, 16 output strobes (after the pixel
   // stream for LOAD), then busy low. Muted stub never answers.
   initial begin
      stub_busy        = 1'b0;
      lcd_output_valid = 1'b0;
      forever begin
         step();
         if (lcd_cmd_valid === 1'b1) begin
            issued_q.push_back(lcd_cmd);
            issue_cnt++;
            if (!stub_mute) begin
               stub_busy = 1'b1;
               repeat ((lcd_cmd == 3'd0) ? 110 : 3) step();
               for (int i = 0; i < 16; i++) begin
                  lcd_output_valid = 1'b1;
                  step();
                  lcd_output_valid = 1'b0;
                  step();
               end
               stub_busy = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         done_ids.push_back(done_id);
      end
      if (err === 1'b1)
         err_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed=running expected=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] exp_full [6];
      int b;
      exp_full = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd2};
      reset = 1'b1; hold_busy = 1'b0; stub_mute = 1'b0;
      req0_cmd = '0; req1_cmd = '0; req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 0; k < 128; k++) pix_mem[k] = 8'((k * 37 + 5) & 8'hff);

      // Reset state
      repeat (3) step();
      chk("rst_cmd_valid", lcd_cmd_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_pix_addr", pix_addr, 0);
      chk("rst_datain", lcd_datain, 0);
      chk("rst_lcd_cmd", lcd_cmd, 0);
      chk("rst_ready0", req0_ready, 0);
      reset = 1'b0;
      step();
      chk("ready0_after_rst", req0_ready, 1);
      chk("ready1_after_rst", req1_ready, 1);

      // ZOOM_IN before any LOAD: dropped with err, never issued
      req1_cmd = 3'd1; req1_valid = 1'b1; step(); req1_valid = 1'b0;
      repeat (8) step();
      chk("noload_err", err_cnt, 1);
      chk("noload_issue", issue_cnt, 0);
      chk("noload_done", done_cnt, 0);

      // LOAD from req0: pixel stream
      req0_cmd = 3'd0; req0_valid = 1'b1; step(); req0_valid = 1'b0;
      b = 0;
      while (lcd_cmd_valid !== 1'b1 && b < 20) begin step(); b++; end
      chk("load_issue", lcd_cmd_valid, 1);
      chk("load_cmd", lcd_cmd, 0);
      for (int k = 0; k < 108; k++) begin
         chk("load_addr", pix_addr, k);
         if (k > 0) chk("load_data", lcd_datain, pix_mem[k-1]);
         step();
      end
      chk("load_data_last", lcd_datain, pix_mem[107]);
      chk("load_addr_wrap", pix_addr, 0);
      wait_done(1);
      chk("load_done_id", done_ids[0], 0);

      // Both requesters push two commands in the same cycles
      req0_cmd = 3'd3; req1_cmd = 3'd5; req0_valid = 1'b1; req1_valid = 1'b1; step();
      req0_cmd = 3'd4; req1_cmd = 3'd6; step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_done(5);
      chk("rr_issue0", issued_q[1], 5);
      chk("rr_issue1", issued_q[2], 3);
      chk("rr_issue2", issued_q[3], 6);
      chk("rr_issue3", issued_q[4], 4);
      chk("rr_id0", done_ids[1], 1);
      chk("rr_id1", done_ids[2], 0);
      chk("rr_id2", done_ids[3], 1);
      chk("rr_id3", done_ids[4], 0);

      // Reserved code then ZOOM_FIT
      req0_cmd = 3'd7; req0_valid = 1'b1; step();
      req0_cmd = 3'd2; step(); req0_valid = 1'b0;
      wait_done(6);
      chk("rsvd_err", err_cnt, 2);
      chk("rsvd_next_issue", issued_q[5], 2);
      chk("rsvd_next_id", done_ids[5], 0);

      // FIFO0 fills while the LCD is held busy
      hold_busy = 1'b1;
      req0_cmd = 3'd1; req0_valid = 1'b1; step(); req0_valid = 1'b0;
      repeat (6) step();
      chk("held_no_issue", issue_cnt, 6);
      for (int i = 0; i < 4; i++) begin
         req0_cmd = 3'(3 + i); req0_valid = 1'b1;
         chk("fill_ready", req0_ready, 1);
         step();
      end
      req0_cmd = 3'd2;
      chk("full_ready", req0_ready, 0);
      repeat (4) step();
      chk("full_ready_hold", req0_ready, 0);
      hold_busy = 1'b0;
      b = 0;
      while (req0_ready !== 1'b1 && b < 200) begin step(); b++; end
      chk("ready_after_pop", req0_ready, 1);
      step();
      req0_valid = 1'b0;
      wait_done(12);
      for (int i = 0; i < 6; i++) chk("full_order", issued_q[6+i], exp_full[i]);
      chk("full_no_err", err_cnt, 2);

`ifdef LCD_CMD_WDOG_EN
      // Silent LCD: watchdog abandons the command
      stub_mute = 1'b1;
      req1_cmd = 3'd3; req1_valid = 1'b1; step(); req1_valid = 1'b0;
      b = 0;
      while (err_cnt < 3 && b < 400) begin step(); b++; end
      chk("wdog_err", err_cnt, 3);
      chk("wdog_no_done", done_cnt, 12);
      stub_mute = 1'b0;
      req1_cmd = 3'd4; req1_valid = 1'b1; step(); req1_valid = 1'b0;
      wait_done(13);
      chk("wdog_recover_id", done_ids[12], 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
